bpred_gshare_btb: RTL and testbench

//  Parametrised gshare direction predictor with a tagged direct-mapped BTB and a registered prediction.

---
 rtl/bpred_gshare_btb.sv | 181 ++++++++++++++++++
 tb/tb_bpred_gshare_btb.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/bpred_gshare_btb.sv
// bpred_gshare_btb
//   Gshare direction predictor with a tagged, direct-mapped BTB and a
//   registered (one-cycle) prediction. A speculative global history register
//   is shifted on predicted conditional hits and repaired on mispredicts.
//   Optional return-address stack: define BPRED_RAS_EN.
//
// Ports
//   clk, rst                clock, asynchronous active-low reset
//   req_valid, req_pc       fetch lookup request
//   pred_valid/taken/target prediction, valid one cycle after req_valid
//   pred_ghr                history used for the lookup, travels with the branch
//   upd_valid, upd_pc       resolved control-flow instruction from EX
//   upd_ghr                 pred_ghr it was predicted with
//   upd_type                00 cond, 01 call, 10 ret, 11 uncond jump
//   upd_taken, upd_target   actual outcome
//   upd_mispred             direction or target was mispredicted
module bpred_gshare_btb #(
    parameter int GHR_W     = 8,
    parameter int PHT_IDX_W = 10,
    parameter int CTR_W     = 2,
    parameter int BTB_IDX_W = 6,
    parameter int BTB_TAG_W = 10,
    parameter int RAS_DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    input  logic [31:0]      req_pc,
    output logic             pred_valid,
    output logic             pred_taken,
    output logic [31:0]      pred_target,
    output logic [GHR_W-1:0] pred_ghr,
    input  logic             upd_valid,
    input  logic [31:0]      upd_pc,
    input  logic [GHR_W-1:0] upd_ghr,
    input  logic [1:0]       upd_type,
    input  logic             upd_taken,
    input  logic [31:0]      upd_target,
    input  logic             upd_mispred
);

    localparam int PHT_N = 1 << PHT_IDX_W;
    localparam int BTB_N = 1 << BTB_IDX_W;
    localparam logic [CTR_W-1:0] CTR_WNT = {1'b0, {(CTR_W-1){1'b1}}};
    localparam logic [CTR_W-1:0] CTR_MAX = {CTR_W{1'b1}};
    localparam logic [1:0] T_COND = 2'b00;
    localparam logic [1:0] T_CALL = 2'b01;
    localparam logic [1:0] T_RET  = 2'b10;

    logic [CTR_W-1:0]     pht        [PHT_N];
    logic                 btb_valid  [BTB_N];
    logic [BTB_TAG_W-1:0] btb_tag    [BTB_N];
    logic [31:0]          btb_target [BTB_N];
    logic [1:0]           btb_type   [BTB_N];
    logic [GHR_W-1:0]     ghr;

    // Lookup path
    logic [PHT_IDX_W-1:0] lk_pidx;
    logic [BTB_IDX_W-1:0] lk_bidx;
    logic                 lk_hit, lk_cond, lk_dir, lk_taken;
    logic [31:0]          lk_target;

    assign lk_pidx  = req_pc[PHT_IDX_W+1:2] ^ PHT_IDX_W'(ghr);
    assign lk_bidx  = req_pc[BTB_IDX_W+1:2];
    assign lk_hit   = btb_valid[lk_bidx] && (btb_tag[lk_bidx] == req_pc[BTB_IDX_W+2 +: BTB_TAG_W]);
    assign lk_cond  = (btb_type[lk_bidx] == T_COND);
    assign lk_dir   = pht[lk_pidx][CTR_W-1];
    assign lk_taken = lk_hit && (!lk_cond || lk_dir);

`ifdef BPRED_RAS_EN
    localparam int RAS_W = $clog2(RAS_DEPTH);

    logic [31:0]    ras [RAS_DEPTH];
    logic [RAS_W-1:0] ras_ptr;   // next slot to write; top of stack is ras_ptr-1
    logic [RAS_W:0]   ras_cnt;
    logic           ras_push, ras_pop;

    assign ras_push = req_valid && lk_hit && (btb_type[lk_bidx] == T_CALL);
    // Popping an empty stack falls back to the BTB target.
    assign ras_pop  = req_valid && lk_hit && (btb_type[lk_bidx] == T_RET) && (ras_cnt != '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ras_ptr <= '0;
            ras_cnt <= '0;
        end else if (ras_push) begin
            // Circular: a push onto a full stack overwrites the oldest entry.
            ras_ptr <= ras_ptr + RAS_W'(1);
            if (ras_cnt != (RAS_W+1)'(RAS_DEPTH)) ras_cnt <= ras_cnt + (RAS_W+1)'(1);
        end else if (ras_pop) begin
            ras_ptr <= ras_ptr - RAS_W'(1);
            ras_cnt <= ras_cnt - (RAS_W+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (ras_push) ras[ras_ptr] <= req_pc + 32'd4;
    end

    always_comb begin
        lk_target = req_pc + 32'd4;
        if (lk_taken) lk_target = btb_target[lk_bidx];
        if (ras_pop)  lk_target = ras[ras_ptr - RAS_W'(1)];
    end
`else
    localparam int unused_ras_depth = RAS_DEPTH;
    logic unused_ret;
    assign unused_ret = (T_RET == T_CALL);

    always_comb begin
        lk_target = req_pc + 32'd4;
        if (lk_taken) lk_target = btb_target[lk_bidx];
    end
`endif

    // Registered prediction
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pred_valid  <= 1'b0;
            pred_taken  <= 1'b0;
            pred_target <= '0;
            pred_ghr    <= '0;
        end else begin
            pred_valid  <= req_valid;
            pred_taken  <= req_valid && lk_taken;
            pred_target <= req_valid ? lk_target : '0;
            pred_ghr    <= req_valid ? ghr : '0;
        end
    end

    // Speculative history; a mispredict repair wins over the lookup shift.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ghr <= '0;
        end else if (upd_valid && upd_mispred) begin
            ghr <= (upd_type == T_COND) ? {upd_ghr[GHR_W-2:0], upd_taken} : upd_ghr;
        end else if (req_valid && lk_hit && lk_cond) begin
            ghr <= {ghr[GHR_W-2:0], lk_dir};
        end
    end

    // Update path
    logic [PHT_IDX_W-1:0] up_pidx;
    logic [BTB_IDX_W-1:0] up_bidx;
    logic [CTR_W-1:0]     up_ctr;
    logic                 unused_upd_pc;

    assign up_pidx       = upd_pc[PHT_IDX_W+1:2] ^ PHT_IDX_W'(upd_ghr);
    assign up_bidx       = upd_pc[BTB_IDX_W+1:2];
    assign up_ctr        = pht[up_pidx];
    assign unused_upd_pc = ^upd_pc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < PHT_N; i++) pht[i] <= CTR_WNT;
        end else if (upd_valid && (upd_type == T_COND)) begin
            if (upd_taken && (up_ctr != CTR_MAX))
                pht[up_pidx] <= up_ctr + CTR_W'(1);
            else if (!upd_taken && (up_ctr != '0))
                pht[up_pidx] <= up_ctr - CTR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < BTB_N; i++) btb_valid[i] <= 1'b0;
        end else if (upd_valid && upd_taken) begin
            btb_valid[up_bidx] <= 1'b1;
        end
    end

    // Payload is only visible behind a valid bit, so it needs no reset.
    always_ff @(posedge clk) begin
        if (upd_valid && upd_taken) begin
            btb_tag[up_bidx]    <= upd_pc[BTB_IDX_W+2 +: BTB_TAG_W];
            btb_target[up_bidx] <= upd_target;
            btb_type[up_bidx]   <= upd_type;
        end
    end

endmodule

// File: tb/tb_bpred_gshare_btb.sv
module tb_bpred_gshare_btb;

    localparam logic [1:0] T_COND = 2'b00;
    localparam logic [1:0] T_CALL = 2'b01;
    localparam logic [1:0] T_RET  = 2'b10;
    localparam logic [1:0] T_JMP  = 2'b11;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic [31:0] req_pc;
    logic        pred_valid;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic [7:0]  pred_ghr;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic [7:0]  upd_ghr;
    logic [1:0]  upd_type;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_mispred;

    int n_tests = 0;
    int n_fail  = 0;

    bpred_gshare_btb dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_pc      (req_pc),
        .pred_valid  (pred_valid),
        .pred_taken  (pred_taken),
        .pred_target (pred_target),
        .pred_ghr    (pred_ghr),
        .upd_valid   (upd_valid),
        .upd_pc      (upd_pc),
        .upd_ghr     (upd_ghr),
        .upd_type    (upd_type),
        .upd_taken   (upd_taken),
        .upd_target  (upd_target),
        .upd_mispred (upd_mispred)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input logic [31:0] pc);
        req_valid = 1'b1;
        req_pc    = pc;
    endtask

    task automatic set_upd(input logic [31:0] pc, input logic [7:0] g, input logic [1:0] ty,
                           input logic tk, input logic [31:0] tgt, input logic mp);
        upd_valid   = 1'b1;
        upd_pc      = pc;
        upd_ghr     = g;
        upd_type    = ty;
        upd_taken   = tk;
        upd_target  = tgt;
        upd_mispred = mp;
    endtask

    task automatic clear_in();
        req_valid   = 1'b0;
        req_pc      = '0;
        upd_valid   = 1'b0;
        upd_pc      = '0;
        upd_ghr     = '0;
        upd_type    = '0;
        upd_taken   = 1'b0;
        upd_target  = '0;
        upd_mispred = 1'b0;
    endtask

    // Inputs present across one rising edge; outputs sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
        clear_in();
    endtask

    task automatic lookup(input logic [31:0] pc);
        set_req(pc);
        tick();
    endtask

    task automatic update(input logic [31:0] pc, input logic [7:0] g, input logic [1:0] ty,
                          input logic tk, input logic [31:0] tgt, input logic mp);
        set_upd(pc, g, ty, tk, tgt, mp);
        tick();
    endtask

    // Not-taken jump flagged as mispredicted: loads the GHR, touches nothing else.
    task automatic set_ghr(input logic [7:0] g);
        update(32'h0, g, T_JMP, 1'b0, 32'h0, 1'b1);
    endtask

    initial begin
        clear_in();
        rst = 1'b0;
        #2;
        chk("rst_valid",  {31'b0, pred_valid}, 32'd0);
        chk("rst_taken",  {31'b0, pred_taken}, 32'd0);
        chk("rst_target", pred_target, 32'd0);
        chk("rst_ghr",    {24'b0, pred_ghr}, 32'd0);
        #12;
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Cold miss
        lookup(32'h100);
        chk("miss_valid",  {31'b0, pred_valid}, 32'd1);
        chk("miss_taken",  {31'b0, pred_taken}, 32'd0);
        chk("miss_target", pred_target, 32'h104);
        chk("miss_ghr",    {24'b0, pred_ghr}, 32'd0);
        tick();
        chk("idle_valid",  {31'b0, pred_valid}, 32'd0);

        // Two taken updates: counter 1 -> 3, BTB written
        update(32'h200, 8'h00, T_COND, 1'b1, 32'h300, 1'b0);
        update(32'h200, 8'h00, T_COND, 1'b1, 32'h300, 1'b0);
        lookup(32'h200);
        chk("cond_taken",  {31'b0, pred_taken}, 32'd1);
        chk("cond_target", pred_target, 32'h300);
        chk("cond_ghr",    {24'b0, pred_ghr}, 32'd0);
        lookup(32'h100);     // same BTB index, different tag
        chk("alias_miss",  {31'b0, pred_taken}, 32'd0);
        chk("spec_shift",  {24'b0, pred_ghr}, 32'd1);

        // Saturation at both ends (PHT entry for 0x280 with history 0)
        for (int i = 0; i < 5; i++) update(32'h280, 8'h00, T_COND, 1'b1, 32'h380, 1'b0);
        set_ghr(8'h00);
        lookup(32'h280);
        chk("sat_hi_taken",  {31'b0, pred_taken}, 32'd1);
        chk("sat_hi_target", pred_target, 32'h380);
        update(32'h280, 8'h00, T_COND, 1'b0, 32'h0, 1'b0);   // 3 -> 2
        set_ghr(8'h00);
        lookup(32'h280);
        chk("ctr2_taken", {31'b0, pred_taken}, 32'd1);
        update(32'h280, 8'h00, T_COND, 1'b0, 32'h0, 1'b0);   // 2 -> 1
        set_ghr(8'h00);
        lookup(32'h280);
        chk("ctr1_taken", {31'b0, pred_taken}, 32'd0);
        update(32'h280, 8'h00, T_COND, 1'b0, 32'h0, 1'b0);   // 1 -> 0
        update(32'h280, 8'h00, T_COND, 1'b0, 32'h0, 1'b0);   // holds 0
        set_ghr(8'h00);
        lookup(32'h280);
        chk("sat_lo_taken", {31'b0, pred_taken}, 32'd0);

        // Repair beats the same-cycle speculative shift
        set_ghr(8'h00);
        set_req(32'h200);
        set_upd(32'h200, 8'h5A, T_COND, 1'b1, 32'h300, 1'b1);
        tick();
        chk("rep_valid",  {31'b0, pred_valid}, 32'd1);
        chk("rep_taken",  {31'b0, pred_taken}, 32'd1);
        chk("rep_target", pred_target, 32'h300);
        chk("rep_ghr",    {24'b0, pred_ghr}, 32'd0);
        lookup(32'h100);
        chk("repaired_ghr", {24'b0, pred_ghr}, 32'hB5);

        // Same-cycle read and write of one entry: old value returned
        set_ghr(8'h00);
        set_req(32'h500);
        set_upd(32'h500, 8'h00, T_COND, 1'b1, 32'h600, 1'b0);
        tick();
        chk("nobyp_taken",  {31'b0, pred_taken}, 32'd0);
        chk("nobyp_target", pred_target, 32'h504);
        lookup(32'h500);
        chk("after_wr_taken",  {31'b0, pred_taken}, 32'd1);
        chk("after_wr_target", pred_target, 32'h600);

        // Return (empty stack / no stack) and jump use the BTB target, no history shift
        update(32'h840, 8'h00, T_RET, 1'b1, 32'h900, 1'b0);
        lookup(32'h840);
        chk("ret_taken",  {31'b0, pred_taken}, 32'd1);
        chk("ret_target", pred_target, 32'h900);
        update(32'h2C0, 8'h00, T_JMP, 1'b1, 32'h1234, 1'b0);
        lookup(32'h2C0);
        chk("jmp_taken",  {31'b0, pred_taken}, 32'd1);
        chk("jmp_target", pred_target, 32'h1234);
        lookup(32'h100);
        chk("noncond_ghr", {24'b0, pred_ghr}, 32'd1);

`ifdef BPRED_RAS_EN
        update(32'h400, 8'h00, T_CALL, 1'b1, 32'h1000, 1'b0);
        lookup(32'h400);
        chk("call_target", pred_target, 32'h1000);
        update(32'h800, 8'h00, T_RET, 1'b1, 32'h900, 1'b0);
        lookup(32'h800);
        chk("ras_target", pred_target, 32'h404);
        for (int i = 0; i < 9; i++)
            update(32'h404 + 32'(4 * i), 8'h00, T_CALL, 1'b1, 32'h1000, 1'b0);
        for (int i = 0; i < 9; i++) lookup(32'h404 + 32'(4 * i));
        for (int j = 0; j < 9; j++) begin
            lookup(32'h840);
            chk("ras_deep", pred_target, (j < 8) ? (32'h428 - 32'(4 * j)) : 32'h900);
        end
`endif

        // Reset in the middle of an update
        set_upd(32'h600, 8'h00, T_COND, 1'b1, 32'h700, 1'b0);
        #3;
        rst = 1'b0;
        #1;
        chk("mid_rst_valid",  {31'b0, pred_valid}, 32'd0);
        chk("mid_rst_target", pred_target, 32'd0);
        @(posedge clk);
        #1;
        clear_in();
        #3;
        rst = 1'b1;
        @(posedge clk);
        #1;
        lookup(32'h600);
        chk("post_rst_discard", {31'b0, pred_taken}, 32'd0);
        chk("post_rst_target",  pred_target, 32'h604);
        lookup(32'h840);
        chk("post_rst_btb", {31'b0, pred_taken}, 32'd0);
        chk("post_rst_ghr", {24'b0, pred_ghr}, 32'd0);
        update(32'h200, 8'h01, T_COND, 1'b1, 32'h300, 1'b0);  // BTB back, other PHT entry
        lookup(32'h200);
        chk("post_rst_ctr_wnt", {31'b0, pred_taken}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
